execute_unit: RTL
=================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  DW, 32, datapath width (must be at least 16).
  MUL_LAT, 4, multiply latency in cycles (must be at least 2).
REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
  clk  in  1  clock, rising edge.
  rst  in  1  reset.
  flush  in  1  kill the in-flight and held instruction.
  in_valid  in  1  decode stage presents an instruction.
  in_ready  out  1  execute stage can accept an instruction.
  ALUctr  in  4  operation code.
  A, B  in  DW  operands.
  NPC  in  DW  next PC.
  imm  in  16  branch offset.
  DX_RD  in  5  destination register.
  DX_MD  in  DW  store data.
  DX_RegWrite, DX_MemtoReg, DX_MemRead, DX_MemWrite, DX_branch  in  1 each  control bits.
  out_valid  out  1  execute/memory register holds a valid instruction.
  out_ready  in  1  memory stage accepts.
  ALUout, XM_BT, XM_MD  out  DW each  result, branch target, store data.
  XM_RD  out  5  destination register.
  XM_RegWrite, XM_MemtoReg, XM_MemRead, XM_MemWrite, XM_branch  out  1 each  registered control bits.
  busy  out  1  a multiply is in progress.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 A transfer SHALL occur when in_valid and in_ready are both high at a rising edge of clk.
REQ-005 in_ready SHALL equal (state==IDLE) and (not out_valid or out_ready) and not flush.
REQ-006 The output register SHALL change only when it is empty or out_ready is high; otherwise all outputs SHALL hold.
REQ-007 For every ALUctr value except 5, the result and all XM_* fields SHALL be registered one cycle after the transfer, with out_valid set to 1.
REQ-008 The ALUctr operations SHALL be: 0 add; 1 sub; 2 and; 3 or; 4 signed slt (1 when A<B, else 0); 5 mul; 6 beq; 7 bne; 8 xor; 9 nor; 10 sll A by B[4:0]; 11 srl A by B[4:0]; any other value gives ALUout=0.
REQ-009 Add, sub and mul SHALL wrap modulo 2^DW; mul SHALL produce the low DW bits of the product.
REQ-010 For beq and bne, ALUout SHALL be 0.
REQ-011 XM_branch SHALL equal DX_branch AND (A==B) for beq, and DX_branch AND (A!=B) for bne; for all other operations it SHALL be 0.
REQ-012 XM_BT SHALL equal NPC + (sign-extended imm shifted left by 2), truncated to DW bits, for every operation.
REQ-013 The state machine SHALL have the states IDLE and MUL.
REQ-014 A transfer with ALUctr=5 SHALL latch the operands and control bits, load a counter with MUL_LAT-1, and move to MUL.
REQ-015 In MUL, busy SHALL be 1 and the counter SHALL decrement once per cycle.
REQ-016 When the counter reaches 0, the product SHALL be written to the output register with out_valid=1, exactly MUL_LAT cycles after the transfer, and the state SHALL return to IDLE.
REQ-017 While in MUL, out_valid SHALL stay 0 once the older result has drained.
REQ-018 The multiply result SHALL wait until the output register is free; the counter SHALL hold at 0 and busy SHALL stay 1 until the write occurs.
REQ-019 flush SHALL force state=IDLE, busy=0 and out_valid=0 at the next edge, and SHALL ignore in_valid in the same cycle; flush has priority over every other event.
REQ-020 When out_valid=0, the XM_RegWrite, XM_MemRead, XM_MemWrite and XM_branch outputs SHALL be 0, so an empty register causes no side effects.
REQ-021 A single-cycle transfer and a drain in the same cycle (out_valid=1, out_ready=1, transfer) SHALL replace the result with no bubble.

Reset
REQ-022 While rst is high at a clock edge, the block SHALL set state=IDLE, counter=0, busy=0 and out_valid=0, and SHALL clear all XM_* control bits, ALUout, XM_BT, XM_MD and XM_RD to 0.
REQ-023 Reset during MUL SHALL abandon the multiply, and no result SHALL appear afterwards.
REQ-024 in_ready SHALL be 0 during reset and 1 in the first cycle after reset.

Verification
REQ-025 With out_ready=1, DW=32: add A=0xFFFFFFFF, B=2 -> one cycle later ALUout=1 and out_valid=1; sub A=3, B=5 -> ALUout=0xFFFFFFFE.
REQ-026 slt A=0xFFFFFFFF (-1), B=1 -> ALUout=1; beq A=B=7, DX_branch=1, NPC=0x100, imm=0xFFFF -> XM_branch=1, XM_BT=0xFC; bne with A=B -> XM_branch=0.
REQ-027 With MUL_LAT=4: mul A=0x10000, B=0x10001 -> in_ready low and busy high for 4 cycles, ALUout=0x10000 with out_valid in cycle 4, in_ready high again in cycle 4.
REQ-028 Hold out_ready=0 with a result held, then issue mul -> the result stays unchanged and busy stays 1 after the count expires; raise out_ready -> the product appears on the next edge.
REQ-029 Assert flush 2 cycles into a mul, and separately assert rst 2 cycles into a mul -> out_valid stays 0, busy=0 next cycle, and no stale product ever appears.
REQ-030 Back-to-back add transfers with out_ready=1 -> out_valid stays high continuously and results appear in order with no bubble.

Source files
------------

// File: rtl/execute_unit.sv
// execute_unit: pipelined ALU/branch execute stage with multi-cycle multiply and valid/ready handshake
// Ports: clk/rst (sync, active-high), flush; in_valid/in_ready + ALUctr, A, B, NPC, imm, DX_* from decode;
//        out_valid/out_ready + ALUout, XM_BT, XM_MD, XM_RD, XM_* control bits to memory; busy while multiplying.
module execute_unit #(
  parameter int DW = 32,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    ALUctr,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] NPC,
  input  logic [15:0]   imm,
  input  logic [4:0]    DX_RD,
  input  logic [DW-1:0] DX_MD,
  input  logic          DX_RegWrite,
  input  logic          DX_MemtoReg,
  input  logic          DX_MemRead,
  input  logic          DX_MemWrite,
  input  logic          DX_branch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ALUout,
  output logic [DW-1:0] XM_BT,
  output logic [DW-1:0] XM_MD,
  output logic [4:0]    XM_RD,
  output logic          XM_RegWrite,
  output logic          XM_MemtoReg,
  output logic          XM_MemRead,
  output logic          XM_MemWrite,
  output logic          XM_branch,
  output logic          busy
);
  localparam int CW = $clog2(MUL_LAT);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DW-1:0] alu, bt, prod, h_a, h_b, h_bt, h_md;
  logic [4:0] h_rd;
  logic [3:0] h_ctl, ctl_q;
  logic br, br_q, can_wr, xfer, is_mul, mul_done;
  assign can_wr   = !out_valid || out_ready;
  assign in_ready = state == IDLE && can_wr && !flush && !rst;
  assign xfer     = in_valid && in_ready;
  assign is_mul   = ALUctr == 4'd5;
  assign mul_done = state == MUL && cnt == '0 && can_wr;
  assign busy     = state == MUL;
  assign prod     = h_a * h_b;
  assign bt       = NPC + DW'({{(DW-16){imm[15]}}, imm, 2'b00});
  assign br       = DX_branch && (ALUctr == 4'd6 ? A == B : ALUctr == 4'd7 && A != B);
  always_comb begin
    case (ALUctr)
      4'd0:    alu = A + B;
      4'd1:    alu = A - B;
      4'd2:    alu = A & B;
      4'd3:    alu = A | B;
      4'd4:    alu = DW'($signed(A) < $signed(B));
      4'd8:    alu = A ^ B;
      4'd9:    alu = ~(A | B);
      4'd10:   alu = A << B[4:0];
      4'd11:   alu = A >> B[4:0];
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (xfer && is_mul) state_n = MUL;
    else if (mul_done) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      {h_a, h_b, h_bt, h_md, h_rd, h_ctl} <= '0;
      {out_valid, ALUout, XM_BT, XM_MD, XM_RD, ctl_q, br_q} <= '0;
    end else if (flush) begin
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      if (xfer && is_mul) begin
        {h_a, h_b, h_bt, h_md, h_rd} <= {A, B, bt, DX_MD, DX_RD};
        h_ctl <= {DX_RegWrite, DX_MemtoReg, DX_MemRead, DX_MemWrite};
        cnt <= CW'(MUL_LAT - 1);
      end else if (state == MUL && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (xfer && !is_mul) begin
        {out_valid, ALUout, XM_BT, XM_MD, XM_RD, br_q} <= {1'b1, alu, bt, DX_MD, DX_RD, br};
        ctl_q <= {DX_RegWrite, DX_MemtoReg, DX_MemRead, DX_MemWrite};
      end else if (mul_done) begin
        {out_valid, ALUout, XM_BT, XM_MD, XM_RD, br_q} <= {1'b1, prod, h_bt, h_md, h_rd, 1'b0};
        ctl_q <= h_ctl;
      end else if (can_wr) begin
        out_valid <= 1'b0;
      end
    end
  end
  // Side-effecting controls are masked so an empty register can never trigger a write or branch.
  assign XM_RegWrite = ctl_q[3] && out_valid;
  assign XM_MemtoReg = ctl_q[2];
  assign XM_MemRead  = ctl_q[1] && out_valid;
  assign XM_MemWrite = ctl_q[0] && out_valid;
  assign XM_branch   = br_q && out_valid;
endmodule
